// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with branch, jump, call/return
// through a hardware return stack, stall, and halt with key-driven restart.
//
// Ports:
//   clock, reset        single clock; synchronous active-low reset
//   halt, resume        halt request; debounced key level, rising edge restarts
//   stall               freezes all state while running
//   branch_taken/offset conditional redirect to PC+1+offset
//   jump, call, ret     absolute jump, push-and-jump, pop into PC
//   jump_target         absolute target for jump/call
//   program_counter     registered instruction address
//   running             1 in RUN, 0 in HALTED
//   stack_level         number of valid return-stack entries
//   stack_overflow/underflow  sticky error flags, cleared only by reset
module pc_sequencer #(
    parameter int unsigned           ADDR_WIDTH  = 10,
    parameter int unsigned           IMM_WIDTH   = 32,
    parameter int unsigned           STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 halt,
    input  logic                                 resume,
    input  logic                                 stall,
    input  logic                                 branch_taken,
    input  logic [IMM_WIDTH-1:0]                 branch_offset,
    input  logic                                 jump,
    input  logic                                 call,
    input  logic                                 ret,
    input  logic [ADDR_WIDTH-1:0]                jump_target,
    output logic [ADDR_WIDTH-1:0]                program_counter,
    output logic                                 running,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_level,
    output logic                                 stack_overflow,
    output logic                                 stack_underflow
);

    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_HALTED = 1'b1;

    logic                  state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  running_d;
    logic [LVL_W-1:0]      level_d;
    logic                  ovf_d, unf_d;
    logic                  resume_q;
    logic                  push_c;

    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_branch;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  resume_rise;

    // Only the low ADDR_WIDTH bits of the offset matter once the sum wraps.
    generate
        if (IMM_WIDTH > ADDR_WIDTH) begin : g_off_unused
            logic unused_offset_hi;
            assign unused_offset_hi = ^branch_offset[IMM_WIDTH-1:ADDR_WIDTH];
        end
    endgenerate

    assign pc_inc      = program_counter + ADDR_WIDTH'(1);
    assign pc_branch   = pc_inc + branch_offset[ADDR_WIDTH-1:0];
    assign stack_full  = (stack_level == LVL_W'(STACK_DEPTH));
    assign stack_empty = (stack_level == '0);
    assign stack_top   = stack_mem[IDX_W'(stack_level - LVL_W'(1))];
    assign resume_rise = resume & ~resume_q;

    // Next-state and next-output selection; priority order inside RUN.
    always_comb begin
        state_d   = state_q;
        pc_d      = program_counter;
        level_d   = stack_level;
        ovf_d     = stack_overflow;
        unf_d     = stack_underflow;
        push_c    = 1'b0;
        running_d = running;

        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    pc_d = program_counter;
                end else if (halt) begin
                    state_d = ST_HALTED;
                end else if (ret) begin
                    if (!stack_empty) begin
                        pc_d    = stack_top;
                        level_d = stack_level - LVL_W'(1);
                    end else begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end
                end else if (call) begin
                    pc_d = jump_target;
                    if (!stack_full) begin
                        push_c  = 1'b1;
                        level_d = stack_level + LVL_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (jump) begin
                    pc_d = jump_target;
                end else if (branch_taken) begin
                    pc_d = pc_branch;
                end else begin
                    pc_d = pc_inc;
                end
            end
            ST_HALTED: begin
                // Restart skips past the halting instruction.
                if (resume_rise) begin
                    state_d = ST_RUN;
                    pc_d    = pc_inc;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        running_d = (state_d == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= ST_RUN;
            program_counter <= RESET_ADDR;
            running         <= 1'b1;
            stack_level     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            resume_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            program_counter <= pc_d;
            running         <= running_d;
            stack_level     <= level_d;
            stack_overflow  <= ovf_d;
            stack_underflow <= unf_d;
            resume_q        <= resume;
        end
    end

    // Return-stack storage; contents are not cleared by reset.
    always_ff @(posedge clock) begin
        if (reset && push_c) begin
            stack_mem[IDX_W'(stack_level)] <= pc_inc;
        end
    end

endmodule
